// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Iterative double-dabble binary-to-BCD converter, one bit per clock,
//            with start/busy/done handshake, overflow flag and optional
//            leading-zero blanking (enabled by defining BIN2BCD_BLANK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_cnt_w = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    logic [BIN_W-1:0]     r_shift_bin;
    logic [c_bcd_w-1:0]   r_bcd;
    logic [c_bcd_w-1:0]   r_bcd_out;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ovf_sticky;
    logic                 r_overflow;
    logic                 r_busy;
    logic                 r_done;

    logic [c_bcd_w-1:0]   w_adj;
    logic [c_bcd_w-1:0]   w_bcd_next;
    logic                 w_ovf_next;

    // Add-3 correction per digit; the 4-bit sum deliberately drops its carry.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign w_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? (r_bcd[4*d +: 4] + 4'd3)
                                                             : r_bcd[4*d +: 4];
    end

    assign w_bcd_next = {w_adj[c_bcd_w-2:0], r_shift_bin[BIN_W-1]};
    assign w_ovf_next = r_ovf_sticky | w_adj[c_bcd_w-1];

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_zero_above;
    logic [DIGITS-1:0] w_blank_next;

    // w_zero_above[d]: digit d and every more significant digit are zero.
    for (genvar d = 0; d < DIGITS; d++) begin : g_zero
        if (d == DIGITS - 1) begin : g_top
            assign w_zero_above[d] = (w_bcd_next[4*d +: 4] == 4'd0);
        end else begin : g_mid
            assign w_zero_above[d] = (w_bcd_next[4*d +: 4] == 4'd0) & w_zero_above[d+1];
        end
    end

    // Units digit is never blanked so zero still shows a single "0".
    assign w_blank_next = w_ovf_next ? '0 : (w_zero_above & ~DIGITS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank <= ~DIGITS'(1);
        end else if (r_state == SHIFT && r_cnt == c_cnt_w'(1)) begin
            r_blank <= w_blank_next;
        end
    end

    assign blank = r_blank;
`else
    assign blank = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift_bin  <= '0;
            r_bcd        <= '0;
            r_bcd_out    <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift_bin  <= bin_in;
                        r_bcd        <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_cnt        <= c_cnt_w'(BIN_W);
                        r_busy       <= 1'b1;
                        r_state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd        <= w_bcd_next;
                    r_shift_bin  <= r_shift_bin << 1;
                    r_ovf_sticky <= w_ovf_next;
                    r_cnt        <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_bcd_out  <= w_bcd_next;
                        r_overflow <= w_ovf_next;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd_out  = r_bcd_out;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Brief    : Directed self-checking bench for bin2bcd_seq (3-digit and 2-digit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

`ifdef BIN2BCD_BLANK_EN
    localparam bit c_blank_on = 1'b1;
`else
    localparam bit c_blank_on = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [7:0]  bin_a = '0, bin_b = '0;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;
    logic [2:0]  blank_a;
    logic [1:0]  blank_b;

    int n_tests = 0;
    int n_fail  = 0;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a), .blank(blank_a)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b), .blank(blank_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on one DUT and wait (bounded) for done; reports latency and busy cycles.
    task automatic conv(input bit sel, input logic [7:0] v, output int lat, output int bcnt);
        if (sel) begin start_b = 1'b1; bin_b = v; end
        else     begin start_a = 1'b1; bin_a = v; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!(sel ? done_b : done_a) && lat < 20) begin
            if (sel ? busy_b : busy_a) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, dcnt;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ovf",  ovf_a, 0);
        chk("rst_bcd",  bcd_a, 12'h000);
        chk("rst_blank", blank_a, c_blank_on ? 3'b110 : 3'b000);
        chk("rst_blank_b", blank_b, c_blank_on ? 2'b10 : 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // 255: full-latency timing and value
        conv(0, 8'd255, lat, bcnt);
        chk("255_latency", lat, 8);
        chk("255_busy_cycles", bcnt, 8);
        chk("255_busy_in_done", busy_a, 0);
        chk("255_bcd", bcd_a, 12'h255);
        chk("255_ovf", ovf_a, 0);
        chk("255_blank", blank_a, 3'b000);
        @(negedge clk);
        chk("255_done_pulse_width", done_a, 0);

        // 0: blanking of both upper digits
        conv(0, 8'd0, lat, bcnt);
        chk("0_latency", lat, 8);
        chk("0_bcd", bcd_a, 12'h000);
        chk("0_blank", blank_a, c_blank_on ? 3'b110 : 3'b000);

        // 99 then start held high: back-to-back conversions
        start_a = 1'b1;
        bin_a   = 8'd99;
        @(negedge clk);
        bin_a = 8'd5;   // change after acceptance; becomes the next operand
        lat = 0;
        while (!done_a && lat < 20) begin @(negedge clk); lat++; end
        chk("99_latency", lat, 8);
        chk("99_bcd", bcd_a, 12'h099);
        chk("99_blank", blank_a, c_blank_on ? 3'b100 : 3'b000);
        chk("99_busy_in_done", busy_a, 0);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done_a && lat < 30);
        start_a = 1'b0;
        chk("held_start_done_spacing", lat, 9);
        chk("5_bcd", bcd_a, 12'h005);
        chk("5_blank", blank_a, c_blank_on ? 3'b110 : 3'b000);
        repeat (2) @(negedge clk);
        chk("held_start_released_idle", busy_a, 0);

        // DIGITS=2: overflow then recovery
        conv(1, 8'd100, lat, bcnt);
        chk("b100_latency", lat, 8);
        chk("b100_ovf", ovf_b, 1);
        chk("b100_blank", blank_b, 2'b00);
        conv(1, 8'd42, lat, bcnt);
        chk("b42_ovf", ovf_b, 0);
        chk("b42_bcd", bcd_b, 8'h42);
        chk("b42_blank", blank_b, 2'b00);
        conv(1, 8'd7, lat, bcnt);
        chk("b7_bcd", bcd_b, 8'h07);
        chk("b7_blank", blank_b, c_blank_on ? 2'b10 : 2'b00);

        // Start while busy is ignored
        start_a = 1'b1;
        bin_a   = 8'd200;
        @(negedge clk);
        start_a = 1'b0;
        lat = 0;
        while (!done_a && lat < 20) begin
            if (lat == 2) begin start_a = 1'b1; bin_a = 8'd7; end
            else          begin start_a = 1'b0; end
            @(negedge clk);
            lat++;
        end
        start_a = 1'b0;
        chk("200_latency", lat, 8);
        chk("200_bcd", bcd_a, 12'h200);
        chk("200_ovf", ovf_a, 0);
        @(negedge clk);
        chk("200_no_second_conv", busy_a, 0);

        // Asynchronous reset mid-conversion
        start_a = 1'b1;
        bin_a   = 8'd77;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_bcd", bcd_a, 12'h000);
        chk("mid_rst_ovf", ovf_a, 0);
        chk("mid_rst_blank", blank_a, c_blank_on ? 3'b110 : 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_a) dcnt++;
        end
        chk("mid_rst_no_done", dcnt, 0);
        chk("mid_rst_bcd_held", bcd_a, 12'h000);
        conv(0, 8'd123, lat, bcnt);
        chk("123_latency", lat, 8);
        chk("123_bcd", bcd_a, 12'h123);
        chk("123_blank", blank_a, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Iterative, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. Sits between the sensor-processing datapath (heart rate, SpO2, temperature readings) and the 7-segment display driver. It turns a BIN_W-bit unsigned value into DIGITS packed BCD digits. A start/busy/done handshake controls it, and an overflow flag is raised when the value does not fit in DIGITS digits.

## Interface
- BIN_W, default 8: width of binary input; ≥ 2.
- DIGITS, default 3: number of BCD output digits; ≥ 1.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion; sampled only when busy = 0.
- bin_in  in  BIN_W  unsigned value; captured on the accepted start edge only.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse: bcd_out/overflow have just been updated.
- bcd_out  out  4*DIGITS  packed result; digit i at [4i+3:4i], digit 0 = units.
- overflow  out  1  result of the last conversion was truncated.
- blank  out  DIGITS  leading-zero blanking mask, bit i = blank digit i.

## Operation
- States: IDLE, SHIFT.
- IDLE with start = 1:
  - load shift_bin ← bin_in.
  - clear the working BCD register and the sticky overflow bit.
  - load bit counter ← BIN_W.
  - go to SHIFT.
- SHIFT, each cycle:
  - for every 4-bit working digit: if digit ≥ 5, add 3. This is a 4-bit add with the carry discarded.
  - shift the {BCD, shift_bin} concatenation left by 1; the MSB of shift_bin enters BCD bit 0.
  - if the bit leaving BCD bit 4*DIGITS-1 is 1, set the sticky overflow bit.
  - decrement the counter.
- SHIFT with counter reaching 0:
  - on the same edge as the last shift, copy the working BCD to bcd_out and the sticky bit to overflow.
  - pulse done; return to IDLE.
- bcd_out, overflow and blank hold their values until the next completion. They are never updated mid-conversion.
- start while busy = 1 is ignored. bin_in changes after acceptance have no effect.
- Overflow: overflow = 1 exactly when bin_in ≥ 10^DIGITS. In that case bcd_out holds the low DIGITS digits of the algorithm's result; its content is unspecified beyond "no X".
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - busy, done and overflow go to 0.
  - bcd_out goes to all zeros.
  - blank follows the Configuration rule for bcd_out = 0.
  - an in-flight conversion is discarded with no done pulse.

## Timing
- Start accepted at edge k: busy = 1 from edge k until edge k+BIN_W.
- done = 1 for exactly the one cycle following edge k+BIN_W, with new bcd_out/overflow valid in that cycle.
- Latency: BIN_W cycles from accepted start to done.
- busy = 0 in the done cycle. A start in that cycle is accepted, giving a sustained throughput of one conversion per BIN_W+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- BIN2BCD_BLANK_EN defined:
  - blank is registered and updated together with bcd_out.
  - blank[i] = 1 iff digit i and all higher digits are 0, for i ≥ 1.
  - blank[0] is always 0, so a value of 0 displays a single "0".
  - when overflow = 1, blank is all zeros.
- Not defined: blank is tied to all zeros and no blanking logic is synthesised.

## Test plan
- BIN_W=8, DIGITS=3, bin_in=255, start pulse:
  - busy high 8 cycles, then done one cycle.
  - bcd_out=12'h255, overflow=0, blank=3'b000.
- bin_in=0:
  - bcd_out=12'h000.
  - blank=3'b110 with BIN2BCD_BLANK_EN, 3'b000 without.
- bin_in=99 followed by start held high:
  - bcd_out=12'h099, blank=3'b100.
  - second conversion begins in the done cycle, with done pulses 9 cycles apart.
- DIGITS=2:
  - bin_in=100 → overflow=1, blank=2'b00.
  - then bin_in=42 → overflow=0, bcd_out=8'h42.
- Start bin_in=200, then start with bin_in=7 on cycle 3 while busy → second start ignored; result 12'h200 after 8 cycles.
- rst_n low at cycle 4 of a conversion:
  - outputs immediately 0, no done pulse.
  - after release, a fresh start with 123 → bcd_out=12'h123.
